// File: rtl/gt_telem_pkg.sv
// Shared types and constants for the GTP telemetry receive lane.
// Holds the link-controller state encoding, the K28.5 comma symbol,
// counter widths and the per-byte error popcount helper.
package gt_telem_pkg;

  localparam int STATE_W = 3;
  localparam int TIMER_W = 16;
  localparam int CNT_W   = 8;
  localparam int TOTAL_W = 16;
  localparam int DATA_W  = 32;
  localparam int LANES   = 4;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT_RST = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_VERIFY   = 3'd2,
    ST_LINK_UP  = 3'd3,
    ST_RESYNC   = 3'd4
  } link_state_e;

  // Number of bytes flagged as errored in one 4-byte word (0..4).
  function automatic logic [2:0] err_bytes(input logic [LANES-1:0] flags);
    err_bytes = {2'b00, flags[0]} + {2'b00, flags[1]} +
                {2'b00, flags[2]} + {2'b00, flags[3]};
  endfunction

endpackage

// File: rtl/gt_rx_err_window.sv
// Windowed decode-error monitor for the RX lane.
// Counts errored bytes over a window of ERR_WIN cycles while run is high
// and flags overflow in the same cycle the count would exceed ERR_MAX.
// The error of the last window cycle is charged to the closing window.
module gt_rx_err_window
  import gt_telem_pkg::*;
#(
  parameter int unsigned ERR_WIN = 4096,
  parameter int unsigned ERR_MAX = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             run,
  input  logic [LANES-1:0] disperr,
  input  logic [LANES-1:0] notintable,
  output logic [2:0]       err_bytes_s,
  output logic             overflow_s
);

  localparam logic [TIMER_W-1:0] WIN_LAST  = TIMER_W'(ERR_WIN - 1);
  localparam logic [CNT_W:0]     ERR_LIMIT = (CNT_W + 1)'(ERR_MAX);

  logic [TIMER_W-1:0] win_cnt_r;
  logic [CNT_W-1:0]   win_err_r;
  logic [CNT_W:0]     sum_s;
  logic [CNT_W-1:0]   win_err_next_s;
  logic               win_end_s;

  // Error popcount, saturating window sum and same-cycle overflow compare.
  always_comb begin
    err_bytes_s = err_bytes(disperr | notintable);
    sum_s       = {1'b0, win_err_r} + {6'b000000, err_bytes_s};
    win_end_s   = (win_cnt_r == WIN_LAST);
    overflow_s  = run && (sum_s > ERR_LIMIT);
    if (sum_s[CNT_W]) begin
      win_err_next_s = 8'hFF;
    end else begin
      win_err_next_s = sum_s[CNT_W-1:0];
    end
  end

  // Window position and error count; both idle at zero outside LINK_UP.
  always_ff @(posedge clk) begin
    if (srst) begin
      win_cnt_r <= 16'd0;
      win_err_r <= 8'd0;
    end else if (!run) begin
      win_cnt_r <= 16'd0;
      win_err_r <= 8'd0;
    end else if (win_end_s) begin
      win_cnt_r <= 16'd0;
      win_err_r <= 8'd0;
    end else begin
      win_cnt_r <= win_cnt_r + 16'd1;
      win_err_r <= win_err_next_s;
    end
  end

endmodule

// File: rtl/gt_rx_link_ctrl.sv
// Link bring-up and supervision controller for the 32-bit 8b/10b GTP RX lane.
// Sequences comma alignment, verifies K28.5 framing, monitors decode errors
// and requests a GT RX reset on loss of link.
// Optional feature macro: GT_RX_LINK_CTRL_POLARITY_AUTO_EN -- when defined,
// the first ALIGN timeout inverts RX polarity and retries before resync.
module gt_rx_link_ctrl
  import gt_telem_pkg::*;
#(
  parameter int unsigned ALIGN_TIMEOUT       = 65535,
  parameter int unsigned GOOD_COMMAS         = 16,
  parameter int unsigned ERR_WIN             = 4096,
  parameter int unsigned ERR_MAX             = 8,
  parameter int unsigned RST_CYC             = 16,
  parameter logic        RX_POLARITY_DEFAULT = 1'b0
) (
  input  logic                gt0_rxusrclk2_in,
  input  logic                soft_reset_rx_in,
  input  logic                gt0_rxresetdone_in,
  input  logic                gt0_rx_fsm_reset_done_in,
  input  logic [DATA_W-1:0]   gt0_rxdata_in,
  input  logic [LANES-1:0]    gt0_rxcharisk_in,
  input  logic [LANES-1:0]    gt0_rxdisperr_in,
  input  logic [LANES-1:0]    gt0_rxnotintable_in,
  input  logic                gt0_rxbyteisaligned_in,
  input  logic                gt0_rxbyterealign_in,
  output logic                gt0_rxpcommaalignen_out,
  output logic                gt0_rxmcommaalignen_out,
  output logic                gt0_rxpolarity_out,
  output logic                gt0_gtrxreset_out,
  output logic                gt0_data_valid_out,
  output logic                link_up_out,
  output logic [STATE_W-1:0]  state_out,
  output logic [TOTAL_W-1:0]  err_total_out,
  output logic [CNT_W-1:0]    retrain_cnt_out
);

  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(ALIGN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   GOOD_LAST    = CNT_W'(GOOD_COMMAS - 1);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYC - 1);

  link_state_e        state_r, state_next_s;
  logic [TIMER_W-1:0] timer_r, timer_next_s;
  logic [CNT_W-1:0]   good_r, good_next_s;
  logic [CNT_W-1:0]   rst_cnt_r, rst_cnt_next_s;
  logic               polarity_r, polarity_next_s;
  logic               comma_en_r, gtrxreset_r, data_valid_r, link_up_r;
  logic [TOTAL_W-1:0] err_total_r;
  logic [CNT_W-1:0]   retrain_r;
  logic [2:0]         e_s;
  logic               overflow_s;
  logic               clean_comma_s;
  logic [TOTAL_W:0]   total_sum_s;
  logic               unused_data_s;
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
  logic               tally_r, tally_next_s;
`endif

  gt_rx_err_window #(
    .ERR_WIN (ERR_WIN),
    .ERR_MAX (ERR_MAX)
  ) u_err_window (
    .clk         (gt0_rxusrclk2_in),
    .srst        (soft_reset_rx_in),
    .run         (state_r == ST_LINK_UP),
    .disperr     (gt0_rxdisperr_in),
    .notintable  (gt0_rxnotintable_in),
    .err_bytes_s (e_s),
    .overflow_s  (overflow_s)
  );

  // Only byte 0 carries the comma; upper bytes pass through to the deframer.
  assign unused_data_s = ^gt0_rxdata_in[DATA_W-1:8];

  // Clean comma detect and saturating total-error sum.
  always_comb begin
    clean_comma_s = (gt0_rxcharisk_in == 4'b0001) &&
                    (gt0_rxdata_in[7:0] == K28_5) && (e_s == 3'd0);
    total_sum_s   = {1'b0, err_total_r} + {14'd0, e_s};
  end

  // Next-state and counter updates for the link FSM.
  always_comb begin
    state_next_s    = state_r;
    timer_next_s    = timer_r;
    good_next_s     = good_r;
    rst_cnt_next_s  = rst_cnt_r;
    polarity_next_s = polarity_r;
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
    tally_next_s    = tally_r;
`endif
    case (state_r)
      ST_WAIT_RST: begin
        if (gt0_rxresetdone_in && gt0_rx_fsm_reset_done_in) begin
          state_next_s = ST_ALIGN;
          timer_next_s = 16'd0;
        end else begin
          state_next_s = ST_WAIT_RST;
        end
      end
      ST_ALIGN: begin
        if (gt0_rxbyteisaligned_in) begin
          state_next_s = ST_VERIFY;
          good_next_s  = 8'd0;
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
          tally_next_s = 1'b0;
`endif
        end else if (timer_r == TIMEOUT_LAST) begin
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
          if (!tally_r) begin
            polarity_next_s = ~polarity_r;
            timer_next_s    = 16'd0;
            tally_next_s    = 1'b1;
          end else begin
            state_next_s    = ST_RESYNC;
            rst_cnt_next_s  = 8'd0;
            tally_next_s    = 1'b0;
          end
`else
          state_next_s   = ST_RESYNC;
          rst_cnt_next_s = 8'd0;
`endif
        end else begin
          timer_next_s = timer_r + 16'd1;
        end
      end
      ST_VERIFY: begin
        if (!gt0_rxbyteisaligned_in) begin
          state_next_s = ST_ALIGN;
          timer_next_s = 16'd0;
        end else if (e_s != 3'd0) begin
          good_next_s = 8'd0;
        end else if (clean_comma_s) begin
          if (good_r == GOOD_LAST) begin
            state_next_s = ST_LINK_UP;
            good_next_s  = 8'd0;
          end else begin
            good_next_s = good_r + 8'd1;
          end
        end else begin
          good_next_s = good_r;
        end
      end
      ST_LINK_UP: begin
        // Overflow and realign together still yield a single RESYNC entry.
        if (overflow_s || gt0_rxbyterealign_in || !gt0_rxbyteisaligned_in) begin
          state_next_s   = ST_RESYNC;
          rst_cnt_next_s = 8'd0;
        end else begin
          state_next_s = ST_LINK_UP;
        end
      end
      ST_RESYNC: begin
        if (rst_cnt_r == RST_LAST) begin
          state_next_s = ST_WAIT_RST;
        end else begin
          rst_cnt_next_s = rst_cnt_r + 8'd1;
        end
      end
      default: begin
        state_next_s = ST_WAIT_RST;
      end
    endcase
  end

  // State, counters, registered outputs and link statistics.
  always_ff @(posedge gt0_rxusrclk2_in) begin
    if (soft_reset_rx_in) begin
      state_r      <= ST_WAIT_RST;
      timer_r      <= 16'd0;
      good_r       <= 8'd0;
      rst_cnt_r    <= 8'd0;
      polarity_r   <= RX_POLARITY_DEFAULT;
      comma_en_r   <= 1'b0;
      gtrxreset_r  <= 1'b0;
      data_valid_r <= 1'b0;
      link_up_r    <= 1'b0;
      err_total_r  <= 16'd0;
      retrain_r    <= 8'd0;
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
      tally_r      <= 1'b0;
`endif
    end else begin
      state_r      <= state_next_s;
      timer_r      <= timer_next_s;
      good_r       <= good_next_s;
      rst_cnt_r    <= rst_cnt_next_s;
      polarity_r   <= polarity_next_s;
      comma_en_r   <= (state_next_s == ST_ALIGN) || (state_next_s == ST_VERIFY);
      gtrxreset_r  <= (state_next_s == ST_RESYNC);
      data_valid_r <= (state_next_s == ST_VERIFY) || (state_next_s == ST_LINK_UP);
      link_up_r    <= (state_next_s == ST_LINK_UP);
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
      tally_r      <= tally_next_s;
`endif
      if ((state_r != ST_WAIT_RST) && (state_r != ST_RESYNC)) begin
        err_total_r <= total_sum_s[TOTAL_W] ? 16'hFFFF : total_sum_s[TOTAL_W-1:0];
      end else begin
        err_total_r <= err_total_r;
      end
      if ((state_next_s == ST_RESYNC) && (state_r != ST_RESYNC) && (retrain_r != 8'hFF)) begin
        retrain_r <= retrain_r + 8'd1;
      end else begin
        retrain_r <= retrain_r;
      end
    end
  end

  assign gt0_rxpcommaalignen_out = comma_en_r;
  assign gt0_rxmcommaalignen_out = comma_en_r;
  assign gt0_rxpolarity_out      = polarity_r;
  assign gt0_gtrxreset_out       = gtrxreset_r;
  assign gt0_data_valid_out      = data_valid_r;
  assign link_up_out             = link_up_r;
  assign state_out               = state_r;
  assign err_total_out           = err_total_r;
  assign retrain_cnt_out         = retrain_r;

endmodule

// File: tb/tb_gt_rx_link_ctrl.sv
// Directed self-checking bench for gt_rx_link_ctrl (ALIGN_TIMEOUT = 100).
module tb_gt_rx_link_ctrl;

  logic        clk = 1'b0;
  logic        srst;
  logic        resetdone, fsm_done;
  logic [31:0] rxdata;
  logic [3:0]  charisk, disperr, notintable;
  logic        aligned, realign;
  logic        pcomma, mcomma, polarity, gtrxreset, data_valid, link_up;
  logic [2:0]  state;
  logic [15:0] err_total;
  logic [7:0]  retrain;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] COMMA_W = 32'h954AC5BC;
  localparam logic [31:0] DATA_W  = 32'h12345678;

  gt_rx_link_ctrl #(.ALIGN_TIMEOUT(100)) dut (
    .gt0_rxusrclk2_in         (clk),
    .soft_reset_rx_in         (srst),
    .gt0_rxresetdone_in       (resetdone),
    .gt0_rx_fsm_reset_done_in (fsm_done),
    .gt0_rxdata_in            (rxdata),
    .gt0_rxcharisk_in         (charisk),
    .gt0_rxdisperr_in         (disperr),
    .gt0_rxnotintable_in      (notintable),
    .gt0_rxbyteisaligned_in   (aligned),
    .gt0_rxbyterealign_in     (realign),
    .gt0_rxpcommaalignen_out  (pcomma),
    .gt0_rxmcommaalignen_out  (mcomma),
    .gt0_rxpolarity_out       (polarity),
    .gt0_gtrxreset_out        (gtrxreset),
    .gt0_data_valid_out       (data_valid),
    .link_up_out              (link_up),
    .state_out                (state),
    .err_total_out            (err_total),
    .retrain_cnt_out          (retrain)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_comma();
    rxdata = COMMA_W; charisk = 4'b0001;
    step();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_pcomma"}, 32'(pcomma), 32'd0);
    chk({tag, "_mcomma"}, 32'(mcomma), 32'd0);
    chk({tag, "_pol"}, 32'(polarity), 32'd0);
    chk({tag, "_gtrx"}, 32'(gtrxreset), 32'd0);
    chk({tag, "_dv"}, 32'(data_valid), 32'd0);
    chk({tag, "_link"}, 32'(link_up), 32'd0);
    chk({tag, "_errtot"}, 32'(err_total), 32'd0);
    chk({tag, "_retrain"}, 32'(retrain), 32'd0);
  endtask

  initial begin
    int  n_high;
    int  n_align;
    bit  done;
    bit  errk;

    srst = 1'b1; resetdone = 1'b0; fsm_done = 1'b0;
    rxdata = DATA_W; charisk = 4'b0000; disperr = 4'b0000; notintable = 4'b0000;
    aligned = 1'b0; realign = 1'b0;
    repeat (3) step();
    chk_reset_values("rst");

    // Release reset; resetdone pair arrives at cycle 5.
    srst = 1'b0;
    repeat (4) step();
    chk("wait_rst_hold", 32'(state), 32'd0);
    resetdone = 1'b1; fsm_done = 1'b1;
    step();
    chk("align_state", 32'(state), 32'd1);
    chk("align_pcomma", 32'(pcomma), 32'd1);
    chk("align_mcomma", 32'(mcomma), 32'd1);
    chk("align_dv", 32'(data_valid), 32'd0);
    repeat (14) step();
    chk("align_hold", 32'(state), 32'd1);
    aligned = 1'b1;
    step();
    chk("verify_state", 32'(state), 32'd2);
    chk("verify_dv", 32'(data_valid), 32'd1);

    // 10 clean commas, one errored comma, then 16 clean (one data word between).
    repeat (10) send_comma();
    disperr = 4'b0010; send_comma(); disperr = 4'b0000;
    repeat (5) send_comma();
    rxdata = DATA_W; charisk = 4'b0000; step();
    repeat (10) send_comma();
    chk("verify_15_no_link", 32'(link_up), 32'd0);
    chk("verify_15_state", 32'(state), 32'd2);
    send_comma();
    chk("link_up_rise", 32'(link_up), 32'd1);
    chk("link_state", 32'(state), 32'd3);
    chk("link_pcomma", 32'(pcomma), 32'd0);
    chk("link_mcomma", 32'(mcomma), 32'd0);
    chk("link_dv", 32'(data_valid), 32'd1);
    chk("verify_errtot", 32'(err_total), 32'd1);

    // Window 1: 7 early errors plus one on the last cycle; window 2: 8 errors.
    rxdata = DATA_W; charisk = 4'b0000;
    for (int k = 0; k < 4108; k++) begin
      errk = ((k >= 10) && (k <= 16)) || (k == 4095) || ((k >= 4100) && (k <= 4107));
      disperr = errk ? 4'b0001 : 4'b0000;
      step();
      if (k == 4095) chk("win1_end_state", 32'(state), 32'd3);
    end
    chk("win2_8err_link", 32'(link_up), 32'd1);
    chk("win2_8err_state", 32'(state), 32'd3);
    chk("win_errtot", 32'(err_total), 32'd17);

    // Ninth errored byte in window 2 -> RESYNC on the next edge.
    disperr = 4'b0100;
    step();
    disperr = 4'b0000;
    aligned = 1'b0;
    chk("ovf_state", 32'(state), 32'd4);
    chk("ovf_link", 32'(link_up), 32'd0);
    chk("ovf_gtrx", 32'(gtrxreset), 32'd1);
    chk("ovf_retrain", 32'(retrain), 32'd1);
    chk("ovf_dv", 32'(data_valid), 32'd0);
    chk("ovf_errtot", 32'(err_total), 32'd18);
    n_high = 1;
    repeat (15) begin
      step();
      if (gtrxreset) n_high++;
    end
    step();
    chk("gtrx_width", 32'(n_high), 32'd16);
    chk("gtrx_low_after", 32'(gtrxreset), 32'd0);
    chk("resync_to_wait", 32'(state), 32'd0);

    // ALIGN timeout with byteisaligned held low.
    n_align = 0; done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      step();
      if (state == 3'd1) n_align++;
      else done = 1'b1;
    end
    chk("timeout_to_resync", 32'(state), 32'd4);
`ifdef GT_RX_LINK_CTRL_POLARITY_AUTO_EN
    chk("timeout_cycles", 32'(n_align), 32'd200);
    chk("timeout_pol", 32'(polarity), 32'd1);
`else
    chk("timeout_cycles", 32'(n_align), 32'd100);
    chk("timeout_pol", 32'(polarity), 32'd0);
`endif
    chk("timeout_retrain", 32'(retrain), 32'd2);

    // Soft reset during the fifth cycle of the gtrxreset pulse.
    repeat (4) step();
    chk("pulse_c5_gtrx", 32'(gtrxreset), 32'd1);
    srst = 1'b1;
    step();
    chk_reset_values("midrst");
    srst = 1'b0;
    step();
    chk("post_rst_align", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
